// File: rtl/seg_scan_ctrl_pkg.sv
// Shared encodings for the segment scan controller: FSM states, blank pattern, pin polarities.
// Constants only; no latency and no flow control.
package seg_scan_defs;

  localparam logic       ST_BLANK  = 1'b0;
  localparam logic       ST_SHOW   = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Board pins are active-low: anodes, segments and decimal point.
  localparam logic       AN_ON     = 1'b0;
  localparam logic       AN_OFF    = 1'b1;
  localparam logic       DP_ON     = 1'b0;
  localparam logic       DP_OFF    = 1'b1;

endpackage

// File: rtl/seg_scan_ctrl_dec.sv
// Hex nibble to active-low {a,b,c,d,e,f,g} segment pattern, a = bit 6.
// Purely combinational; zero latency, no backpressure.
module hex_seg_decoder
  import seg_scan_defs::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner: per digit slot, BLANK_CYC blank cycles then a SHOW interval.
// All outputs registered on the FSM state edge; free-running, no backpressure.
module seg_scan_ctrl
  import seg_scan_defs::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int TICK_DIV   = 50000,
  parameter  int BLANK_CYC  = 500,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic [IDX_W-1:0]        scan_idx,
  output logic                    frame_done
);

  localparam int               TMR_W      = $clog2(TICK_DIV);
  localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYC - 1);
  localparam logic [TMR_W-1:0] SHOW_LAST  = TMR_W'(TICK_DIV - BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic                  state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [3:0]            nib_q, nib_d;
  logic                  dps_q, dps_d;
  logic                  vis_q, vis_d;
  logic                  fd_q, fd_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dpo_q, dpo_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [NUM_DIGITS-1:0] zero_from;
  logic                  zero_acc;
  logic                  lz_hit;
  logic                  show_vis;
  logic [6:0]            dec_seg;

  // zero_from[i]: every digit from i up to the most significant one is zero.
  always_comb begin
    zero_acc  = 1'b1;
    zero_from = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc     = zero_acc & (digits[4*i +: 4] == 4'h0);
      zero_from[i] = zero_acc;
    end
  end

  assign lz_hit = lz_blank && (idx_q != '0) && zero_from[idx_q];

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 1'b1;
    idx_d   = idx_q;
    nib_d   = nib_q;
    dps_d   = dps_q;
    vis_d   = vis_q;
    fd_d    = 1'b0;
    if (state_q == ST_BLANK) begin
      if (tmr_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        tmr_d   = '0;
        nib_d   = digits[{idx_q, 2'b00} +: 4];
        dps_d   = dp_in[idx_q];
        vis_d   = digit_en[idx_q] && !lz_hit;
      end
    end else begin
      if (tmr_q == SHOW_LAST) begin
        state_d = ST_BLANK;
        tmr_d   = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        fd_d    = (idx_q == IDX_LAST);
      end
    end
  end

  // Decoder sees the snapshot's D side so the segments land on the same edge as SHOW.
  hex_seg_decoder u_dec (
    .nib (nib_d),
    .seg (dec_seg)
  );

  assign show_vis = (state_d == ST_SHOW) && vis_d;

  always_comb begin
    seg_d = show_vis ? dec_seg : SEG_BLANK;
    dpo_d = (show_vis && dps_d) ? DP_ON : DP_OFF;
    an_d  = {NUM_DIGITS{AN_OFF}};
    if (show_vis) begin
      an_d[idx_q] = AN_ON;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_BLANK;
      tmr_q   <= '0;
      idx_q   <= '0;
      nib_q   <= '0;
      dps_q   <= 1'b0;
      vis_q   <= 1'b0;
      fd_q    <= 1'b0;
      seg_q   <= SEG_BLANK;
      dpo_q   <= DP_OFF;
      an_q    <= {NUM_DIGITS{AN_OFF}};
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      dps_q   <= dps_d;
      vis_q   <= vis_d;
      fd_q    <= fd_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
      an_q    <= an_d;
    end
  end

  assign seg_out    = seg_q;
  assign dp_out     = dpo_q;
  assign an_out     = an_q;
  assign scan_idx   = idx_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=4, TICK_DIV=10, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  digit_en = '0;
  logic [3:0]  dp_in = '0;
  logic        lz_blank = 1'b0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic [1:0]  scan_idx;
  logic        frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(4), .TICK_DIV(10), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .digit_en   (digit_en),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .an_out     (an_out),
    .scan_idx   (scan_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]     digits;
    logic [3:0]      en;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0]      vis;
    logic [3:0][6:0] seg;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       fd;
  } obs_t;

  obs_t sb_q[$];
  vec_t tbl[8];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dp,
                              input logic lz, input logic [3:0] vis,
                              input logic [6:0] s3, input logic [6:0] s2,
                              input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.digits = d;
    v.en     = en;
    v.dp     = dp;
    v.lz     = lz;
    v.vis    = vis;
    v.seg    = {s3, s2, s1, s0};
    return v;
  endfunction

  // Expected outputs after rising edge c (c=1 is the first edge after reset release).
  function automatic obs_t model(input vec_t r, input int c);
    obs_t o;
    int   p;
    int   k;
    p     = c % 10;
    k     = (c / 10) % 4;
    o.an  = 4'hF;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.idx = 2'(k);
    o.fd  = (c % 40 == 0);
    if (p >= 2 && r.vis[k]) begin
      o.an[k] = 1'b0;
      o.seg   = r.seg[k];
      o.dp    = ~r.dp[k];
    end
    return o;
  endfunction

  task automatic apply(input vec_t r);
    digits   = r.digits;
    digit_en = r.en;
    dp_in    = r.dp;
    lz_blank = r.lz;
  endtask

  task automatic check_blank(input string name);
    check({name, "_an"},  0, 32'(an_out),     32'hF);
    check({name, "_seg"}, 0, 32'(seg_out),    32'h7F);
    check({name, "_dp"},  0, 32'(dp_out),     32'h1);
    check({name, "_idx"}, 0, 32'(scan_idx),   32'h0);
    check({name, "_fd"},  0, 32'(frame_done), 32'h0);
  endtask

  // Assert reset away from an edge, confirm it acts before the next edge, hold across one edge, release.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_blank("rst_async");
    @(posedge clk);
    @(negedge clk);
    check_blank("rst_hold");
    reset = 1'b1;
  endtask

  task automatic run(input vec_t r, input int c0, input int c1);
    obs_t e;
    for (int c = c0; c <= c1; c++) begin
      sb_q.push_back(model(r, c));
      @(posedge clk);
      @(negedge clk);
      e = sb_q.pop_front();
      check("an",  c, 32'(an_out),     32'(e.an));
      check("seg", c, 32'(seg_out),    32'(e.seg));
      check("dp",  c, 32'(dp_out),     32'(e.dp));
      check("idx", c, 32'(scan_idx),   32'(e.idx));
      check("fd",  c, 32'(frame_done), 32'(e.fd));
    end
  endtask

  initial begin
    vec_t r01;
    vec_t r0f;
    tbl[0] = mk(16'h1234, 4'hF, 4'h0, 1'b0, 4'b1111, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100);
    tbl[1] = mk(16'h0050, 4'hF, 4'h0, 1'b1, 4'b0011, 7'h7F, 7'h7F, 7'b0100100, 7'b0000001);
    tbl[2] = mk(16'h0000, 4'hF, 4'h0, 1'b1, 4'b0001, 7'h7F, 7'h7F, 7'h7F, 7'b0000001);
    tbl[3] = mk(16'h0000, 4'b0101, 4'b0001, 1'b0, 4'b0101, 7'h7F, 7'b0000001, 7'h7F, 7'b0000001);
    tbl[4] = mk(16'hA5F0, 4'hF, 4'b1010, 1'b1, 4'b1111, 7'b0001000, 7'b0100100, 7'b0111000, 7'b0000001);
    tbl[5] = mk(16'h00E0, 4'hF, 4'b0010, 1'b1, 4'b0011, 7'h7F, 7'h7F, 7'b0110000, 7'b0000001);
    tbl[6] = mk(16'h8C96, 4'b1110, 4'b0100, 1'b1, 4'b1110, 7'b0000000, 7'b0110001, 7'b0000100, 7'h7F);
    tbl[7] = mk(16'h7DB3, 4'hF, 4'b0001, 1'b0, 4'b1111, 7'b0001111, 7'b1000010, 7'b1100000, 7'b0000110);
    r01 = mk(16'h0001, 4'hF, 4'h0, 1'b0, 4'b1111, 7'b0000001, 7'b0000001, 7'b0000001, 7'b1001111);
    r0f = mk(16'h000F, 4'hF, 4'h0, 1'b0, 4'b1111, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0111000);

    // Two frames of the first vector cover reset release timing and frame_done period.
    apply(tbl[0]);
    do_reset();
    run(tbl[0], 1, 80);

    for (int i = 1; i < 8; i++) begin
      apply(tbl[i]);
      do_reset();
      run(tbl[i], 1, 40);
    end

    // Input change in the middle of the idx0 SHOW must wait for the next idx0 slot.
    apply(r01);
    do_reset();
    run(r01, 1, 5);
    digits = 16'h000F;
    run(r01, 6, 40);
    run(r0f, 41, 80);

    // Reset during the idx2 SHOW restarts scanning from idx0.
    apply(tbl[0]);
    do_reset();
    run(tbl[0], 1, 25);
    do_reset();
    run(tbl[0], 1, 14);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
